// File: rtl/sm_fetch_queue.sv
`default_nettype none
// ============================================================================
// sm_fetch_queue : instruction prefetch FIFO between PC logic and the ROM.
// Optional ROM-to-decode bypass when empty: define SM_FETCH_QUEUE_BYPASS_EN.
// Revision: 1.0
// ============================================================================

module sm_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_rd,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int                c_aw       = $clog2(DEPTH);
  localparam int                c_lw       = $clog2(DEPTH+1);
  localparam logic [c_lw-1:0]   c_depth    = c_lw'(DEPTH);
  localparam logic [31:0]       c_reset_pc = {RESET_PC[31:2], 2'b00};

  logic [31:0]     r_fetch_pc;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_lw-1:0] r_count;
  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  logic w_bypass;
  logic w_pop;
  logic w_pop_q;
  logic w_push;
  logic w_advance;
  logic w_unused_pc_lsb;

  // Byte-offset bits of the redirect target are deliberately dropped.
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign rom_addr = {2'b00, r_fetch_pc[31:2]};

`ifdef SM_FETCH_QUEUE_BYPASS_EN
  assign w_bypass    = (r_count == '0) & ~redirect_valid;
  assign instr_valid = (r_count != '0) | w_bypass;
  assign instr       = w_bypass ? rom_rd     : r_mem_instr[r_rd_ptr];
  assign instr_pc    = w_bypass ? r_fetch_pc : r_mem_pc[r_rd_ptr];
`else
  assign w_bypass    = 1'b0;
  assign instr_valid = (r_count != '0);
  assign instr       = r_mem_instr[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
`endif

  assign level = r_count;

  // A bypassed transfer consumes the ROM word directly, so storage is untouched.
  assign w_pop     = instr_valid & instr_ready;
  assign w_pop_q   = w_pop & ~w_bypass;
  assign w_push    = ~redirect_valid & ((r_count < c_depth) | w_pop)
                   & ~(w_bypass & instr_ready);
  assign w_advance = w_push | (w_bypass & instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= c_reset_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_advance) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)    r_wr_ptr   <= r_wr_ptr + c_aw'(1);
      if (w_pop_q)   r_rd_ptr   <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop_q})
        2'b10:   r_count <= r_count + c_lw'(1);
        2'b01:   r_count <= r_count - c_lw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= rom_rd;
    end
  end

endmodule

`default_nettype wire
